pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before an attempt counts as failed (>=2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive lock cycles required before releasing the core (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 64: extra cycles core_reset stays high after lock is stable (>=1).
REQ-005 SHALL have parameter MAX_RETRIES, default 7: failed attempts tolerated before FAIL (1..7).
REQ-006 SHALL have port sys_clock, input, 1: the single clock (board oscillator, not the PLL output); all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock, asynchronous to sys_clock.
REQ-009 SHALL have port soft_rst_req, input, 1: single-cycle core re-reset request.
REQ-010 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-011 SHALL have port core_reset, output, 1: active-high reset to the core.
REQ-012 SHALL have port seq_state, output, 3: current state encoding.
REQ-013 SHALL have port retry_cnt, output, 3: failed attempts since the last RUN entry.
REQ-014 SHALL have port fail, output, 1: high in FAIL.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-016 SHALL encode states PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAIL=5; 6-7 unused and decode to PLL_RST.
REQ-017 SHALL use one cycle counter, cleared on every state transition.
REQ-018 SHALL make every output a register with no combinational path from any input.
REQ-019 PLL_RST: pll_rst=1 and core_reset=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_rst=0 and core_reset=1; lock_s=1 goes to STABLE.
REQ-021 WAIT_LOCK timeout: if the counter reaches LOCK_TIMEOUT-1 with lock_s=0, go to FAIL when retry_cnt==MAX_RETRIES, otherwise increment retry_cnt and go to PLL_RST.
REQ-022 STABLE: lock_s must stay 1 for STABLE_CYCLES consecutive cycles before going to HOLD; any lock_s=0 returns to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-023 HOLD: core_reset=1 for HOLD_CYCLES cycles, then go to RUN.
REQ-024 RUN entry: core_reset=0 and retry_cnt=0.
REQ-025 Bring-up timing: if pll_locked rises before edge k and stays high, core_reset SHALL fall at edge k+2+STABLE_CYCLES+HOLD_CYCLES.
REQ-026 RUN, lock_s=0: core_reset=1 on the next edge, go to PLL_RST, retry_cnt unchanged.
REQ-027 RUN, soft_rst_req=1 with lock_s=1: core_reset=1 on the next edge, go to HOLD, pll_rst stays 0.
REQ-028 Lock loss and soft_rst_req together in RUN: lock loss wins (go to PLL_RST).
REQ-029 soft_rst_req SHALL be ignored in PLL_RST, WAIT_LOCK, STABLE and HOLD.
REQ-030 FAIL: pll_rst=0, core_reset=1, fail=1; soft_rst_req leaves FAIL to PLL_RST, clears retry_cnt and clears fail on the same edge.
REQ-031 retry_cnt SHALL never exceed MAX_RETRIES and SHALL not wrap.

Reset
REQ-032 reset_n=0 SHALL immediately (asynchronously) set: state PLL_RST, pll_rst=1, core_reset=1, fail=0, retry_cnt=0, counter=0, synchronizer flops=0.
REQ-033 After reset_n rises, the first PLL_RST period SHALL last the full PLL_RST_CYCLES.
REQ-034 reset_n asserted in any state, including mid-count, SHALL abort the sequence with no partial state kept.

Verification
Test parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, HOLD_CYCLES=4, MAX_RETRIES=2.
REQ-035 Normal bring-up: reset release, then pll_locked=1 sampled at edge k -> pll_rst high for 4 cycles, core_reset falls at edge k+14, seq_state=4.
REQ-036 Lock glitch: pll_locked low for 3 cycles during STABLE -> return to WAIT_LOCK, retry_cnt=0, core_reset stays 1 until a full 8 stable cycles plus 4 hold cycles.
REQ-037 Lock never arrives: pll_locked=0 -> three pll_rst pulses, retry_cnt 0->1->2, then FAIL with fail=1, core_reset=1, pll_rst=0; soft_rst_req pulse -> PLL_RST, fail=0, retry_cnt=0.
REQ-038 Lock loss in RUN -> core_reset=1 at the 3rd edge after pll_locked falls (2 sync plus 1), seq_state=0, core re-released after the full sequence.
REQ-039 soft_rst_req in RUN -> core_reset high for exactly 5 cycles (1 plus HOLD_CYCLES), pll_rst stays 0; a simultaneous lock drop -> seq_state=0.
REQ-040 reset_n pulsed low mid-HOLD -> outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : PLL reset / lock-qualify / core-release sequencer with retries.
// Revision : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       core_reset,
    output logic [2:0] seq_state,
    output logic [2:0] retry_cnt,
    output logic       fail
);

    localparam int c_CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_CNT_MAX_B = (STABLE_CYCLES > HOLD_CYCLES + 1) ? STABLE_CYCLES : HOLD_CYCLES + 1;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > c_CNT_MAX_B) ? c_CNT_MAX_A : c_CNT_MAX_B;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PLL_LAST     = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that saw lock already counts toward the stable run.
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    // HOLD lasts one cycle beyond HOLD_CYCLES so a soft reset gives 1+HOLD_CYCLES.
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(HOLD_CYCLES);
    localparam logic [2:0]         c_MAX_RETRY    = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_retry;
    logic [2:0]         w_retry_nxt;
    logic               r_lock_meta;
    logic               r_lock_s;
    logic               r_pll_rst;
    logic               r_core_reset;
    logic               r_fail;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_state      <= ST_PLL_RST;
            r_cnt        <= '0;
            r_retry      <= 3'd0;
            r_pll_rst    <= 1'b1;
            r_core_reset <= 1'b1;
            r_fail       <= 1'b0;
        end else begin
            r_lock_meta  <= pll_locked;
            r_lock_s     <= r_lock_meta;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_pll_rst    <= (w_state_nxt == ST_PLL_RST);
            r_core_reset <= (w_state_nxt != ST_RUN);
            r_fail       <= (w_state_nxt == ST_FAIL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_retry_nxt = r_retry;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == c_PLL_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    if (r_retry == c_MAX_RETRY) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_retry_nxt = r_retry + 3'd1;
                        w_state_nxt = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = 3'd0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lock_s) begin
                    w_state_nxt = ST_PLL_RST;
                end else if (soft_rst_req) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_FAIL: begin
                w_cnt_nxt = '0;
                if (soft_rst_req) begin
                    w_state_nxt = ST_PLL_RST;
                    w_retry_nxt = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    assign pll_rst    = r_pll_rst;
    assign core_reset = r_core_reset;
    assign fail       = r_fail;
    assign seq_state  = r_state;
    assign retry_cnt  = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Directed bench with a deadline-based reference model of the sequencer.
// Revision : 1.0
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int HOLD_CYCLES    = 4;
    localparam int MAX_RETRIES    = 2;

    localparam int P_PLLRST = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_HOLD   = 3;
    localparam int P_RUN    = 4;
    localparam int P_FAIL   = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       core_reset;
    logic [2:0] seq_state;
    logic [2:0] retry_cnt;
    logic       fail;

    int n_cmp  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .sys_clock   (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .core_reset  (core_reset),
        .seq_state   (seq_state),
        .retry_cnt   (retry_cnt),
        .fail        (fail)
    );

    // Reference model: phases with absolute-edge deadlines and a lock-run length.
    int m_ph      = P_PLLRST;
    int m_edge    = 0;
    int m_end     = PLL_RST_CYCLES;
    int m_run     = 0;
    int m_retries = 0;
    bit hist[$];

    task automatic model_reset();
        m_ph      = P_PLLRST;
        m_edge    = 0;
        m_end     = PLL_RST_CYCLES;
        m_run     = 0;
        m_retries = 0;
        hist.delete();
    endtask

    task automatic enter(input int ph, input int dur);
        m_ph  = ph;
        m_end = m_edge + dur;
    endtask

    task automatic model_step();
        bit ls;
        m_edge++;
        ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        hist.push_back(pll_locked);
        if (hist.size() > 3) void'(hist.pop_front());
        if (m_ph == P_WAIT || m_ph == P_STABLE) m_run = ls ? m_run + 1 : 0;
        else m_run = 0;
        case (m_ph)
            P_PLLRST: if (m_edge >= m_end) enter(P_WAIT, LOCK_TIMEOUT);
            P_WAIT: begin
                if (ls) enter(P_STABLE, 0);
                else if (m_edge >= m_end) begin
                    if (m_retries == MAX_RETRIES) enter(P_FAIL, 0);
                    else begin
                        m_retries++;
                        enter(P_PLLRST, PLL_RST_CYCLES);
                    end
                end
            end
            P_STABLE: begin
                if (!ls) enter(P_WAIT, LOCK_TIMEOUT);
                else if (m_run >= STABLE_CYCLES) enter(P_HOLD, HOLD_CYCLES + 1);
            end
            P_HOLD: if (m_edge >= m_end) begin
                enter(P_RUN, 0);
                m_retries = 0;
            end
            P_RUN: begin
                if (!ls) enter(P_PLLRST, PLL_RST_CYCLES);
                else if (soft_rst_req) enter(P_HOLD, HOLD_CYCLES + 1);
            end
            P_FAIL: if (soft_rst_req) begin
                m_retries = 0;
                enter(P_PLLRST, PLL_RST_CYCLES);
            end
            default: enter(P_PLLRST, PLL_RST_CYCLES);
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_v = {m_ph == P_PLLRST, m_ph != P_RUN, m_ph == P_FAIL, 3'(m_ph), 3'(m_retries)};
                act_v = {pll_rst, core_reset, fail, seq_state, retry_cnt};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL cycle_cmp t=%0t got pll_rst=%b core_reset=%b fail=%b state=%0d retry=%0d, want %b %b %b %0d %0d",
                             $time, act_v[8], act_v[7], act_v[6], act_v[5:3], act_v[2:0],
                             exp_v[8], exp_v[7], exp_v[6], exp_v[5:3], exp_v[2:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until core_reset is observed low; -1 if it never falls.
    task automatic wait_release(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (core_reset === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int hi;
        int pulses;
        int fail_at;
        int max_retry;
        logic prev;
        logic prst_seen;

        reset_n = 1'b0;
        pll_locked = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b1;
        check("reset_pll_rst", pll_rst, 1);
        check("reset_core_reset", core_reset, 1);
        check("reset_fail", fail, 0);
        check("reset_state", seq_state, 0);
        check("reset_retry", retry_cnt, 0);

        // Normal bring-up: lock sampled at edge 5, release expected at edge 19.
        reset_n = 1'b1;
        repeat (3) tick();
        check("pll_rst_edge3", pll_rst, 1);
        tick();
        check("pll_rst_edge4", pll_rst, 0);
        check("wait_lock_state", seq_state, 1);
        pll_locked = 1'b1;
        wait_release(lat);
        check("bringup_latency", lat, 15);
        check("bringup_state", seq_state, 4);
        check("model_in_run", m_ph, P_RUN);

        // Soft reset in RUN.
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("soft_hold_state", seq_state, 3);
        hi = 0;
        prst_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (core_reset !== 1'b1) break;
            hi++;
            prst_seen = prst_seen | pll_rst;
            tick();
        end
        check("soft_core_reset_len", hi, 5);
        check("soft_pll_rst_low", prst_seen, 0);

        // Lock loss with a simultaneous soft request: lock loss wins on 3rd edge.
        pll_locked = 1'b0;
        tick();
        tick();
        check("lockloss_edge2_run", seq_state, 4);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("lockloss_state", seq_state, 0);
        check("lockloss_core_reset", core_reset, 1);
        check("lockloss_retry", retry_cnt, 0);
        pll_locked = 1'b1;
        wait_release(lat);
        check("relock_latency", lat, 17);

        // Lock glitch of 3 cycles during STABLE.
        reset_n = 1'b0;
        pll_locked = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b1;
        repeat (4) tick();
        check("glitch_in_stable", seq_state, 2);
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        check("glitch_back_wait", seq_state, 1);
        check("glitch_retry", retry_cnt, 0);
        wait_release(lat);
        check("glitch_latency", lat, 15);

        // Asynchronous reset in the middle of HOLD.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        tick();
        check("midhold_state", seq_state, 3);
        reset_n = 1'b0;
        #1;
        check("async_rst_pll_rst", pll_rst, 1);
        check("async_rst_core_reset", core_reset, 1);
        check("async_rst_state", seq_state, 0);
        check("async_rst_retry", retry_cnt, 0);
        check("async_rst_fail", fail, 0);
        tick();
        reset_n = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pll_rst === 1'b0) begin
                lat = i;
                break;
            end
        end
        check("post_reset_pll_rst_len", lat, 4);

        // Lock never arrives: three attempts then FAIL; soft pulse in WAIT ignored.
        reset_n = 1'b0;
        pll_locked = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        pulses = 1;
        prev = 1'b1;
        fail_at = -1;
        max_retry = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == 10) soft_rst_req = 1'b1;
            if (i == 11) soft_rst_req = 1'b0;
            tick();
            if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
            prev = pll_rst;
            if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
            if (fail === 1'b1) begin
                fail_at = i;
                break;
            end
        end
        check("fail_edge", fail_at, 108);
        check("fail_pulses", pulses, 3);
        check("fail_max_retry", max_retry, 2);
        check("fail_pll_rst", pll_rst, 0);
        check("fail_core_reset", core_reset, 1);
        check("fail_retry", retry_cnt, 2);
        tick();
        check("fail_sticky", seq_state, 5);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("fail_exit_state", seq_state, 0);
        check("fail_exit_fail", fail, 0);
        check("fail_exit_retry", retry_cnt, 0);
        check("fail_exit_pll_rst", pll_rst, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
